rvga_membus_arbiter: RTL and testbench

RVGA_MEMBUS_ARBITER -- requirements
Module: rvga_membus_arbiter

---
 rtl/rvga_membus_arbiter_pkg.sv | 26 ++
 rtl/rvga_membus_if.sv | 17 +
 rtl/rvga_arb_rr2.sv | 30 +++
 rtl/rvga_membus_arbiter.sv | 108 ++++++++++
 tb/tb_rvga_membus_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rvga_membus_arbiter_pkg.sv
// Shared types for the two-requester memory bus arbiter.
//   rvga_word      : 32-bit bus address
//   rvga_cacheline : 256-bit data beat (one full cache line)
//   arb_state_e    : arbiter FSM states
//   arb_port_e     : identifies a requester (instruction or data side)
package rvga_types;

  typedef logic [31:0]  rvga_word;
  typedef logic [255:0] rvga_cacheline;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_port_e;

  // Bit positions inside the one-hot grant vector.
  localparam int unsigned GRANT_I_BIT = 0;
  localparam int unsigned GRANT_D_BIT = 1;

endpackage

// File: rtl/rvga_membus_if.sv
// Memory bus bundle. A requester holds read or write with stable addr/wdata
// until it sees resp for one cycle, then drops the request next cycle.
//   master : drives addr/read/write/wdata, receives rdata/resp
//   slave  : receives addr/read/write/wdata, drives rdata/resp
interface rvga_membus_if;

  rvga_types::rvga_word      addr;
  logic                      read;
  logic                      write;
  rvga_types::rvga_cacheline wdata;
  rvga_types::rvga_cacheline rdata;
  logic                      resp;

  modport master (output addr, read, write, wdata, input rdata, resp);
  modport slave  (input addr, read, write, wdata, output rdata, resp);

endinterface

// File: rtl/rvga_arb_rr2.sv
// Two-way tie-break, purely combinational.
//   req_i, req_d : instruction / data side request
//   last_grant   : port served by the previous transaction
//   grant        : one-hot, bit GRANT_I_BIT = ibus, GRANT_D_BIT = dbus
// A single requester always wins. On a tie, FAIR_RR=1 picks the port that
// was not served last; FAIR_RR=0 always picks the data side.
module rvga_arb_rr2
  import rvga_types::*;
#(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic       req_i,
  input  logic       req_d,
  input  arb_port_e  last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (req_i && req_d) begin
      if (FAIR_RR && (last_grant == GNT_D)) grant[GRANT_I_BIT] = 1'b1;
      else                                  grant[GRANT_D_BIT] = 1'b1;
    end else if (req_i) begin
      grant[GRANT_I_BIT] = 1'b1;
    end else if (req_d) begin
      grant[GRANT_D_BIT] = 1'b1;
    end
  end

endmodule

// File: rtl/rvga_membus_arbiter.sv
// Arbitrates an instruction-cache port and a data-cache port onto one
// downstream memory port, one transaction at a time.
//   clk_i   : clock, rising edge
//   reset_i : synchronous, active-high
//   ibus    : instruction-side requester (slave)
//   dbus    : data-side requester (slave)
//   mbus    : downstream memory (master)
// The granted request is captured into flops on the IDLE->SERVE edge and
// held until mbus.resp, so requester behaviour during service cannot disturb
// the downstream transaction. resp is routed back combinationally.
module rvga_membus_arbiter
  import rvga_types::*;
#(
  parameter bit FAIR_RR = 1'b1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  rvga_membus_if.slave  ibus,
  rvga_membus_if.slave  dbus,
  rvga_membus_if.master mbus
);

  arb_state_e    state_q, state_d;
  arb_port_e     last_grant_q;
  rvga_word      addr_q;
  logic          read_q, write_q;
  rvga_cacheline wdata_q;

  logic       req_i, req_d;
  logic [1:0] grant;

  assign req_i = ibus.read | ibus.write;
  assign req_d = dbus.read | dbus.write;

  rvga_arb_rr2 #(.FAIR_RR(FAIR_RR)) u_rr2 (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if      (grant[GRANT_D_BIT]) state_d = SERVE_D;
        else if (grant[GRANT_I_BIT]) state_d = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (mbus.resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // read+write together is illegal; read takes precedence downstream.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant[GRANT_D_BIT]) begin
            addr_q  <= dbus.addr;
            read_q  <= dbus.read;
            write_q <= dbus.write & ~dbus.read;
            wdata_q <= dbus.wdata;
          end else if (grant[GRANT_I_BIT]) begin
            addr_q  <= ibus.addr;
            read_q  <= ibus.read;
            write_q <= ibus.write & ~ibus.read;
            wdata_q <= ibus.wdata;
          end
        end
        default: begin
          if (mbus.resp) begin
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            last_grant_q <= (state_q == SERVE_D) ? GNT_D : GNT_I;
          end
        end
      endcase
    end
  end

  assign mbus.addr  = addr_q;
  assign mbus.read  = read_q;
  assign mbus.write = write_q;
  assign mbus.wdata = wdata_q;

  // resp in IDLE (or during reset) belongs to nobody and is dropped.
  assign ibus.resp  = ~reset_i & (state_q == SERVE_I) & mbus.resp;
  assign dbus.resp  = ~reset_i & (state_q == SERVE_D) & mbus.resp;
  assign ibus.rdata = mbus.rdata;
  assign dbus.rdata = mbus.rdata;

  a_ibus_rw_excl: assert property (@(posedge clk_i) disable iff (reset_i)
                                   !(ibus.read && ibus.write));
  a_dbus_rw_excl: assert property (@(posedge clk_i) disable iff (reset_i)
                                   !(dbus.read && dbus.write));

endmodule

// File: tb/tb_rvga_membus_arbiter.sv
// Bench for rvga_membus_arbiter. Two instances share all requester/memory
// stimulus: dut0 with FAIR_RR=1, dut1 with FAIR_RR=0; 'sel' picks which
// instance's outputs are observed. Traffic runs are checked against a
// transaction-level model: queued requests per port, arbitration decided
// from the visible requests whenever the model is idle.
module tb_rvga_membus_arbiter;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk = ~clk;

  logic         i_read = 0, i_write = 0, d_read = 0, d_write = 0, m_resp = 0;
  logic [31:0]  i_addr = 0, d_addr = 0;
  logic [255:0] i_wdata = 0, d_wdata = 0, m_rdata = 0;
  bit           sel = 1'b0;

  rvga_membus_if ibus0 (), dbus0 (), mbus0 ();
  rvga_membus_if ibus1 (), dbus1 (), mbus1 ();

  assign ibus0.read = i_read;  assign ibus0.write = i_write;
  assign ibus0.addr = i_addr;  assign ibus0.wdata = i_wdata;
  assign dbus0.read = d_read;  assign dbus0.write = d_write;
  assign dbus0.addr = d_addr;  assign dbus0.wdata = d_wdata;
  assign mbus0.resp = m_resp;  assign mbus0.rdata = m_rdata;
  assign ibus1.read = i_read;  assign ibus1.write = i_write;
  assign ibus1.addr = i_addr;  assign ibus1.wdata = i_wdata;
  assign dbus1.read = d_read;  assign dbus1.write = d_write;
  assign dbus1.addr = d_addr;  assign dbus1.wdata = d_wdata;
  assign mbus1.resp = m_resp;  assign mbus1.rdata = m_rdata;

  rvga_membus_arbiter #(.FAIR_RR(1'b1)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .ibus(ibus0), .dbus(dbus0), .mbus(mbus0));
  rvga_membus_arbiter #(.FAIR_RR(1'b0)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .ibus(ibus1), .dbus(dbus1), .mbus(mbus1));

  logic         o_mread, o_mwrite, o_iresp, o_dresp;
  logic [31:0]  o_maddr;
  logic [255:0] o_mwdata, o_irdata, o_drdata;

  always_comb begin
    o_mread  = sel ? mbus1.read  : mbus0.read;
    o_mwrite = sel ? mbus1.write : mbus0.write;
    o_maddr  = sel ? mbus1.addr  : mbus0.addr;
    o_mwdata = sel ? mbus1.wdata : mbus0.wdata;
    o_iresp  = sel ? ibus1.resp  : ibus0.resp;
    o_dresp  = sel ? dbus1.resp  : dbus0.resp;
    o_irdata = sel ? ibus1.rdata : ibus0.rdata;
    o_drdata = sel ? dbus1.rdata : dbus0.rdata;
  end

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]  addr;
    bit           we;
    logic [255:0] wdata;
    int           start;
  } txn_t;

  typedef struct {
    int   port;   // 0 = ibus, 1 = dbus
    txn_t t;
    int   cyc;    // cycle in which the model granted it
  } exp_t;

  txn_t qi[$], qd[$];
  exp_t expq[$];
  int   served[$];

  // Inputs are applied 1 time unit after the rising edge; outputs are
  // sampled 1 unit later, well away from either edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0; m_resp = 0;
    i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0; m_rdata = 0;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    clear_inputs();
    repeat (2) step();
    reset_i = 1'b0;
  endtask

  // Requesters present queued transactions from their start cycle on, drop
  // for one cycle after each resp; memory answers lat cycles after it first
  // sees a request (random 1..4 when lat_fixed is 0).
  task automatic run_traffic(input int lat_fixed, input int budget);
    bit   fair, drop_i, drop_d, busy, mem_act, resp_prev, pi, pd;
    int   cyc, cnt, last;
    exp_t cur, e;
    fair = (sel == 1'b0);
    cyc = 0; cnt = 0; last = 0;
    drop_i = 0; drop_d = 0; busy = 0; mem_act = 0; resp_prev = 0;
    cur.port = 0; cur.cyc = 0; cur.t.addr = 0; cur.t.we = 0; cur.t.wdata = 0; cur.t.start = 0;
    served.delete();
    expq.delete();
    while ((qi.size() > 0 || qd.size() > 0 || busy || mem_act) && cyc < budget) begin
      step();
      if (resp_prev) busy = 0;
      pi = (qi.size() > 0) && !drop_i && (cyc >= qi[0].start);
      pd = (qd.size() > 0) && !drop_d && (cyc >= qd[0].start);
      if (pi) begin
        i_read = !qi[0].we; i_write = qi[0].we; i_addr = qi[0].addr; i_wdata = qi[0].wdata;
      end else begin
        i_read = 0; i_write = 0;
      end
      if (pd) begin
        d_read = !qd[0].we; d_write = qd[0].we; d_addr = qd[0].addr; d_wdata = qd[0].wdata;
      end else begin
        d_read = 0; d_write = 0;
      end
      drop_i = 0; drop_d = 0;
      m_resp = 0;
      if (mem_act) begin
        cnt--;
        if (cnt == 0) begin
          m_resp = 1;
          m_rdata = {8{$urandom}};
        end
      end
      #1;
      if (!busy && (pi || pd)) begin
        if (pi && pd) e.port = fair ? ((last == 0) ? 1 : 0) : 1;
        else          e.port = pd ? 1 : 0;
        e.t = e.port ? qd[0] : qi[0];
        e.cyc = cyc;
        expq.push_back(e);
        busy = 1;
        last = e.port;
      end
      if (resp_prev) begin
        n_chk++;
        if ({o_mread, o_mwrite} !== 2'b00) begin
          n_fail++;
          $display("FAIL idle_gap cyc=%0d: mbus rd/wr=%b required 00", cyc, {o_mread, o_mwrite});
        end
      end
      if (m_resp) begin
        n_chk++;
        if ({o_iresp, o_dresp} !== (cur.port ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL resp_route cyc=%0d: {iresp,dresp}=%b required %b", cyc,
                   {o_iresp, o_dresp}, (cur.port ? 2'b01 : 2'b10));
        end
        n_chk++;
        if (o_irdata !== m_rdata || o_drdata !== m_rdata) begin
          n_fail++;
          $display("FAIL rdata_route cyc=%0d: irdata=%h drdata=%h required %h", cyc,
                   o_irdata, o_drdata, m_rdata);
        end
        served.push_back(cur.port);
        if (cur.port == 1) begin drop_d = 1; void'(qd.pop_front()); end
        else               begin drop_i = 1; void'(qi.pop_front()); end
        mem_act = 0;
        resp_prev = 1;
      end else begin
        resp_prev = 0;
        n_chk++;
        if ({o_iresp, o_dresp} !== 2'b00) begin
          n_fail++;
          $display("FAIL spurious_resp cyc=%0d: {iresp,dresp}=%b required 00", cyc, {o_iresp, o_dresp});
        end
        if (mem_act) begin
          n_chk++;
          if ({o_mread, o_mwrite, o_maddr} !== {~cur.t.we, cur.t.we, cur.t.addr} ||
              (cur.t.we && o_mwdata !== cur.t.wdata)) begin
            n_fail++;
            $display("FAIL hold cyc=%0d: rd=%b wr=%b addr=%h required rd=%b wr=%b addr=%h", cyc,
                     o_mread, o_mwrite, o_maddr, ~cur.t.we, cur.t.we, cur.t.addr);
          end
        end else if (o_mread || o_mwrite) begin
          n_chk++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_txn cyc=%0d: addr=%h rd=%b wr=%b required none", cyc,
                     o_maddr, o_mread, o_mwrite);
          end else begin
            cur = expq.pop_front();
            if (cur.cyc + 1 != cyc || o_maddr !== cur.t.addr || o_mread !== ~cur.t.we ||
                o_mwrite !== cur.t.we || (cur.t.we && o_mwdata !== cur.t.wdata)) begin
              n_fail++;
              $display("FAIL txn cyc=%0d: port? addr=%h rd=%b wr=%b required port%0d addr=%h we=%b at cyc %0d",
                       cyc, o_maddr, o_mread, o_mwrite, cur.port, cur.t.addr, cur.t.we, cur.cyc + 1);
            end
            mem_act = 1;
            cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
          end
        end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL missing_txn cyc=%0d: mbus idle required port%0d addr=%h", cyc,
                   expq[0].port, expq[0].t.addr);
          void'(expq.pop_front());
          busy = 0;
        end
      end
      cyc++;
    end
    if (cyc >= budget) begin
      n_chk++;
      n_fail++;
      $display("FAIL traffic_timeout: %0d cycles used, budget %0d", cyc, budget);
    end
    qi.delete();
    qd.delete();
    clear_inputs();
  endtask

  task automatic push_txn(input bit to_d, input logic [31:0] addr, input bit we,
                          input logic [255:0] wdata, input int start);
    txn_t t;
    t.addr = addr; t.we = we; t.wdata = wdata; t.start = start;
    if (to_d) qd.push_back(t);
    else      qi.push_back(t);
  endtask

  task automatic test_reset;
    sel = 0;
    reset_i = 1'b1;
    i_read = 1; i_addr = 32'h1111_0000; d_write = 1; d_addr = 32'h2222_0000; d_wdata = 256'hffff;
    m_resp = 1; m_rdata = 256'h5a5a;
    step(); step();
    #1;
    n_chk++;
    if ({o_mread, o_mwrite, o_maddr, o_mwdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mbus: rd=%b wr=%b addr=%h wdata=%h required all 0", o_mread, o_mwrite, o_maddr, o_mwdata);
    end
    n_chk++;
    if ({o_iresp, o_dresp} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_resp: {iresp,dresp}=%b required 00", {o_iresp, o_dresp});
    end
    reset_i = 1'b0;
    clear_inputs();
  endtask

  task automatic test_single_read;
    logic [255:0] a5;
    sel = 0;
    a5 = {32{8'hA5}};
    do_reset();
    step(); i_read = 1; i_addr = 32'h0000_1000; #1;
    n_chk++;
    if (o_mread !== 1'b0) begin
      n_fail++; $display("FAIL single_c0: mbus read=%b required 0", o_mread);
    end
    step(); #1;
    n_chk++;
    if ({o_mread, o_mwrite, o_maddr} !== {1'b1, 1'b0, 32'h0000_1000}) begin
      n_fail++; $display("FAIL single_c1: rd=%b wr=%b addr=%h required 1 0 00001000", o_mread, o_mwrite, o_maddr);
    end
    step(); step(); step(); m_resp = 1; m_rdata = a5; #1;
    n_chk++;
    if ({o_iresp, o_dresp} !== 2'b10 || o_irdata !== a5) begin
      n_fail++; $display("FAIL single_resp: {iresp,dresp}=%b rdata=%h required 10 %h", {o_iresp, o_dresp}, o_irdata, a5);
    end
    step(); m_resp = 0; i_read = 0; #1;
    n_chk++;
    if ({o_mread, o_iresp, o_dresp} !== 3'b000) begin
      n_fail++; $display("FAIL single_done: rd=%b iresp=%b dresp=%b required 000", o_mread, o_iresp, o_dresp);
    end
  endtask

  task automatic test_tie_first;
    sel = 0;
    do_reset();
    push_txn(1'b0, 32'h100, 1'b0, 256'h0, 0);
    push_txn(1'b1, 32'h200, 1'b1, 256'h1234, 0);
    run_traffic(2, 100);
    n_chk++;
    if (served.size() != 2 || served[0] != 1 || served[1] != 0) begin
      n_fail++; $display("FAIL tie_order: served %0d txns first=%0d required 2 txns D then I",
                         served.size(), (served.size() > 0) ? served[0] : -1);
    end
  endtask

  task automatic test_alternate;
    logic [5:0] got;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int k = 0; k < 3; k++) begin
        push_txn(1'b0, $urandom & 32'hffff_ffe0, 1'b0, {8{$urandom}}, 0);
        push_txn(1'b1, $urandom & 32'hffff_ffe0, 1'b1, {8{$urandom}}, 0);
      end
      run_traffic(0, 200);
      got = '0;
      for (int k = 0; k < 6 && k < served.size(); k++) got[k] = served[k][0];
      n_chk++;
      if (served.size() != 6 || got !== 6'b010101) begin
        n_fail++; $display("FAIL alternate sel=%0d: grants=%b (%0d) required 010101 (6)", s, got, served.size());
      end
    end
  endtask

  // A solo dbus transaction between two tie rounds separates the modes.
  task automatic test_tie_policy;
    logic [4:0] got;
    logic [4:0] want;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      want = (s == 0) ? 5'b10101 : 5'b01101;
      do_reset();
      push_txn(1'b1, 32'h300, 1'b1, 256'h11, 0);
      push_txn(1'b1, 32'h340, 1'b0, 256'h0, 20);
      push_txn(1'b1, 32'h380, 1'b1, 256'h22, 40);
      push_txn(1'b0, 32'h500, 1'b0, 256'h0, 0);
      push_txn(1'b0, 32'h540, 1'b0, 256'h0, 40);
      run_traffic(2, 200);
      got = '0;
      for (int k = 0; k < 5 && k < served.size(); k++) got[k] = served[k][0];
      n_chk++;
      if (served.size() != 5 || got !== want) begin
        n_fail++; $display("FAIL tie_policy sel=%0d: grants=%b (%0d) required %b (5)", s, got, served.size(), want);
      end
    end
  endtask

  task automatic test_random;
    int ti, td;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      ti = 0; td = 0;
      for (int k = 0; k < 12; k++) begin
        ti += $urandom_range(0, 6);
        td += $urandom_range(0, 6);
        push_txn(1'b0, $urandom & 32'hffff_ffe0, $urandom_range(0, 1) == 1, {8{$urandom}}, ti);
        push_txn(1'b1, $urandom & 32'hffff_ffe0, $urandom_range(0, 1) == 1, {8{$urandom}}, td);
      end
      run_traffic(0, 2000);
      n_chk++;
      if (served.size() != 24) begin
        n_fail++; $display("FAIL random_count sel=%0d: served %0d required 24", s, served.size());
      end
    end
  endtask

  task automatic test_hold_mid_change;
    logic [255:0] w1, rd;
    sel = 0;
    w1 = 256'h1234_5678;
    rd = 256'hdead_beef;
    do_reset();
    step(); d_write = 1; d_addr = 32'h300; d_wdata = w1; #1;
    step(); #1;
    n_chk++;
    if ({o_mwrite, o_mread, o_maddr, o_mwdata} !== {1'b1, 1'b0, 32'h300, w1}) begin
      n_fail++; $display("FAIL hold_c1: wr=%b rd=%b addr=%h wdata=%h required 1 0 300 %h", o_mwrite, o_mread, o_maddr, o_mwdata, w1);
    end
    step(); d_addr = 32'h400; d_wdata = 256'h9999; #1;
    n_chk++;
    if ({o_mwrite, o_mread, o_maddr, o_mwdata} !== {1'b1, 1'b0, 32'h300, w1}) begin
      n_fail++; $display("FAIL hold_changed: wr=%b addr=%h wdata=%h required 1 300 %h", o_mwrite, o_maddr, o_mwdata, w1);
    end
    step(); d_write = 0; #1;
    n_chk++;
    if ({o_mwrite, o_maddr, o_mwdata} !== {1'b1, 32'h300, w1}) begin
      n_fail++; $display("FAIL hold_dropped: wr=%b addr=%h required 1 300", o_mwrite, o_maddr);
    end
    step(); m_resp = 1; m_rdata = rd; #1;
    n_chk++;
    if ({o_iresp, o_dresp} !== 2'b01 || o_drdata !== rd) begin
      n_fail++; $display("FAIL hold_resp: {iresp,dresp}=%b rdata=%h required 01 %h", {o_iresp, o_dresp}, o_drdata, rd);
    end
    step(); m_resp = 0; #1;
    n_chk++;
    if ({o_mwrite, o_mread, o_dresp} !== 3'b000) begin
      n_fail++; $display("FAIL hold_done: wr=%b rd=%b dresp=%b required 000", o_mwrite, o_mread, o_dresp);
    end
  endtask

  task automatic test_reset_mid;
    sel = 0;
    do_reset();
    step(); i_read = 1; i_addr = 32'h40; #1;
    step(); #1;
    n_chk++;
    if (o_mread !== 1'b1) begin
      n_fail++; $display("FAIL rmid_serve: mbus read=%b required 1", o_mread);
    end
    step(); reset_i = 1'b1; m_resp = 1; #1;
    n_chk++;
    if ({o_iresp, o_dresp} !== 2'b00) begin
      n_fail++; $display("FAIL rmid_resp_in_reset: {iresp,dresp}=%b required 00", {o_iresp, o_dresp});
    end
    step(); reset_i = 1'b0; i_read = 0; m_resp = 1; #1;
    n_chk++;
    if ({o_mread, o_mwrite, o_maddr, o_mwdata, o_iresp, o_dresp} !== '0) begin
      n_fail++; $display("FAIL rmid_after: rd=%b wr=%b addr=%h iresp=%b dresp=%b required all 0",
                         o_mread, o_mwrite, o_maddr, o_iresp, o_dresp);
    end
    step(); m_resp = 0; d_read = 1; d_addr = 32'h80; #1;
    step(); #1;
    n_chk++;
    if ({o_mread, o_maddr} !== {1'b1, 32'h80}) begin
      n_fail++; $display("FAIL rmid_idle: rd=%b addr=%h required 1 00000080", o_mread, o_maddr);
    end
    step(); m_resp = 1; #1;
    n_chk++;
    if ({o_iresp, o_dresp} !== 2'b01) begin
      n_fail++; $display("FAIL rmid_next_resp: {iresp,dresp}=%b required 01", {o_iresp, o_dresp});
    end
    step(); m_resp = 0; d_read = 0;
  endtask

  task automatic test_idle_resp;
    sel = 0;
    do_reset();
    step(); m_resp = 1; m_rdata = 256'h77; #1;
    n_chk++;
    if ({o_iresp, o_dresp, o_mread, o_mwrite} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_resp: iresp=%b dresp=%b rd=%b wr=%b required 0000", o_iresp, o_dresp, o_mread, o_mwrite);
    end
    step(); m_resp = 0; i_read = 1; i_addr = 32'h20; #1;
    n_chk++;
    if ({o_mread, o_mwrite} !== 2'b00) begin
      n_fail++; $display("FAIL idle_resp_after: rd=%b wr=%b required 00", o_mread, o_mwrite);
    end
    step(); #1;
    n_chk++;
    if ({o_mread, o_maddr} !== {1'b1, 32'h20}) begin
      n_fail++; $display("FAIL idle_resp_state: rd=%b addr=%h required 1 00000020", o_mread, o_maddr);
    end
    step(); m_resp = 1; #1;
    n_chk++;
    if ({o_iresp, o_dresp} !== 2'b10) begin
      n_fail++; $display("FAIL idle_resp_serve: {iresp,dresp}=%b required 10", {o_iresp, o_dresp});
    end
    step(); m_resp = 0; i_read = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie_first();
    test_alternate();
    test_tie_policy();
    test_hold_mid_change();
    test_reset_mid();
    test_idle_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
